vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
//
// PURPOSE
// - Raster timing generator: produces pixel/line counters plus hsync, vsync, blank for the video output path.
// - Sits upstream of the pixel pipeline and the sync-alignment delay line.
// - hsync/vsync/blank leave here undelayed. Downstream they are delayed by the pixel-pipeline depth so they stay aligned with processed pixel data.
// - One instance per display; all outputs are registered.
//
// PARAMETERS
// H_ACTIVE  1024  visible pixels per line
// H_FP      24    horizontal front porch (pixels)
// H_SYNC    136   horizontal sync width (pixels)
// H_BP      160   horizontal back porch (pixels)
// V_ACTIVE  768   visible lines per frame
// V_FP      3     vertical front porch (lines)
// V_SYNC    6     vertical sync width (lines)
// V_BP      29    vertical back porch (lines)
// HS_POL    0     hsync active level (0 = active-low)
// VS_POL    0     vsync active level (0 = active-low)
// HW        11    hcount width; must satisfy 2**HW >= H_TOTAL
// VW        10    vcount width; must satisfy 2**VW >= V_TOTAL
//
// PORTS
// clk          in   1   pixel-domain clock
// rst          in   1   synchronous, active-high reset
// pix_en       in   1   pixel clock enable; counters advance only when high
// hcount       out  HW  current pixel column, 0..H_TOTAL-1
// vcount       out  VW  current line, 0..V_TOTAL-1
// hsync        out  1   horizontal sync, polarity HS_POL
// vsync        out  1   vertical sync, polarity VS_POL
// blank        out  1   high outside the active area
// line_start   out  1   one-clk pulse when hcount wraps to 0
// frame_start  out  1   one-clk pulse when (hcount,vcount) wraps to (0,0)
//
// BEHAVIOUR
// - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
// - Reset values:
//   - hcount=0, vcount=0, blank=0.
//   - hsync=~HS_POL, vsync=~VS_POL.
//   - line_start=0, frame_start=0.
// - rst has priority over pix_en.
// - Reset asserted mid-frame forces the reset values at the next edge, with no pulses.
// - pix_en=1 at an edge:
//   - hcount increments; at H_TOTAL-1 it wraps to 0.
//   - On the hcount wrap, vcount increments; at V_TOTAL-1 it wraps to 0.
// - pix_en=0: every output holds its value. line_start and frame_start clear to 0.
// - hsync/vsync/blank are computed from the next counter values and registered in the same edge, so they always describe the hcount/vcount currently presented.
// - hsync = HS_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
// - vsync = VS_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. It is independent of hcount; vsync changes only on line boundaries.
// - blank = (hcount >= H_ACTIVE) | (vcount >= V_ACTIVE).
// - line_start is high for exactly one clk, coinciding with hcount becoming 0 via wrap.
// - frame_start is high for exactly one clk, coinciding with (0,0) reached via wrap.
// - No line_start or frame_start pulse follows reset release.
// - All comparisons are unsigned at HW/VW width. No counter may ever exceed its TOTAL-1.
// - Latency: counters/syncs update on the same edge at which pix_en is sampled high.
//
// STRUCTURE
// - Shared include file video_timing.vh holds:
//   - timing presets (XGA 1024x768@60, VGA 640x480@60) as parameter sets;
//   - the derived H_TOTAL/V_TOTAL constants;
//   - the sync-polarity defines.
// - Single module, no sub-modules. Next-state logic is combinational, with one registered output stage.
//
// TESTING  (small params: H 8/2/3/3 => H_TOTAL=16; V 4/1/2/1 => V_TOTAL=8)
// 1. Reset, then pix_en=1 constantly:
//    - hcount runs 0..15 and wraps; vcount steps on each 15->0 transition.
//    - Frame period is 128 clks.
// 2. Same run:
//    - hsync=0 exactly at hcount 10..12.
//    - blank=1 for hcount 8..15, and for every hcount while vcount is 4..7.
// 3. Same run:
//    - vsync=0 for all of vcount 5..6.
//    - line_start pulses every 16 clks; frame_start pulses every 128 clks at (0,0).
//    - Neither pulse appears right after reset.
// 4. pix_en high 1 clk in 3:
//    - Counters advance only on enabled clks; frame period is 384 clks.
//    - Pulses stay 1 clk wide.
// 5. rst=1 while at (5,2) with pix_en=1:
//    - Next edge gives (0,0), hsync=vsync=1, blank=0, no pulses.
// 6. HS_POL=1, VS_POL=1:
//    - hsync=1 only at hcount 10..12; vsync=1 only at vcount 5..6.
//    - Both idle low after reset.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_pkg
//
// Purpose : Shared raster-timing constants for the video output path.
//           Holds the standard timing presets (XGA 1024x768@60 and
//           VGA 640x480@60), the sync polarity encodings, and helpers that
//           derive the total line/frame lengths from a preset.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package vga_timing_gen_pkg;

  // Sync polarity encodings: the level a sync output takes while asserted.
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // XGA 1024x768 @ 60 Hz (65 MHz pixel clock), both syncs negative.
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam bit XGA_HS_POL   = SYNC_ACTIVE_LOW;
  localparam bit XGA_VS_POL   = SYNC_ACTIVE_LOW;

  // VGA 640x480 @ 60 Hz (25.175 MHz pixel clock), both syncs negative.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_HS_POL   = SYNC_ACTIVE_LOW;
  localparam bit VGA_VS_POL   = SYNC_ACTIVE_LOW;

  // Total pixels per line / lines per frame for a given set of intervals.
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Derived totals for the presets.
  localparam int XGA_H_TOTAL = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int XGA_V_TOTAL = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose : Raster timing generator. Produces the pixel column / line
//           counters plus hsync, vsync and blank for one display. All
//           outputs are registered; sync/blank are derived from the next
//           counter values so they always describe the hcount/vcount being
//           presented in the same cycle. Downstream logic delays the syncs
//           to match the pixel pipeline depth.
//
// Ports   :
//   clk          in   1   pixel-domain clock
//   rst          in   1   synchronous, active-high reset (priority over pix_en)
//   pix_en       in   1   pixel clock enable; counters advance only when high
//   hcount       out  HW  current pixel column, 0..H_TOTAL-1
//   vcount       out  VW  current line, 0..V_TOTAL-1
//   hsync        out  1   horizontal sync, asserted level HS_POL
//   vsync        out  1   vertical sync, asserted level VS_POL
//   blank        out  1   high outside the active area
//   line_start   out  1   one-clk pulse when hcount wraps to 0
//   frame_start  out  1   one-clk pulse when (hcount,vcount) wraps to (0,0)
// ---------------------------------------------------------------------------
import vga_timing_gen_pkg::*;

module vga_timing_gen #(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit HS_POL   = XGA_HS_POL,
  parameter bit VS_POL   = XGA_VS_POL,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Counter boundaries at counter width so every compare is unsigned HW/VW.
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blank_q, blank_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en) begin
      // '>=' rather than '==' so a corrupted counter still returns to 0.
      if (h_q >= H_LAST) begin
        h_d          = '0;
        line_start_d = 1'b1;
        if (v_q >= V_LAST) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    // Decoded from the next counter values so the registered flags line up
    // with the registered counters. When pix_en is low h_d/v_d equal the
    // current counters, so these reproduce the held values.
    hsync_d = ((h_d >= HS_START) && (h_d < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d = ((v_d >= VS_START) && (v_d < VS_END)) ? VS_POL : ~VS_POL;
    blank_d = (h_d >= H_ACT_END) || (v_d >= V_ACT_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Small raster: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8).
// u_dut uses active-low syncs, u_pol the same timing with active-high syncs;
// both share clock, reset and enable.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic       clk;
  logic       rst;
  logic       pix_en;
  logic [3:0] hcount, hcount_p;
  logic [2:0] vcount, vcount_p;
  logic       hsync, vsync, blank, line_start, frame_start;
  logic       hsync_p, vsync_p, blank_p, line_start_p, frame_start_p;

  int checks = 0;
  int errors = 0;

  // Reference state
  int   e_h, e_v;
  logic e_ls, e_fs;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .HW(4), .VW(3)
  ) u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .blank(blank), .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .HW(4), .VW(3)
  ) u_pol (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hcount_p), .vcount(vcount_p), .hsync(hsync_p), .vsync(vsync_p),
    .blank(blank_p), .line_start(line_start_p), .frame_start(frame_start_p)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: low-polarity instance fields, then the high-polarity
  // instance's counters, syncs, blank and pulses.
  function automatic logic [27:0] obs_vec();
    return {hcount, vcount, hsync, vsync, blank, line_start, frame_start,
            hcount_p, vcount_p, hsync_p, vsync_p, blank_p, line_start_p,
            frame_start_p};
  endfunction

  // Expected vector from hand-written window constants.
  function automatic logic [27:0] exp_vec(input int h, input int v,
                                          input logic ls, input logic fs,
                                          input logic after_reset);
    logic hs_act, vs_act, bl;
    hs_act = (h >= 10) && (h <= 12);
    vs_act = (v >= 5) && (v <= 6);
    bl     = after_reset ? 1'b0 : ((h >= 8) || (v >= 4));
    return {4'(h), 3'(v), ~hs_act, ~vs_act, bl, ls, fs,
            4'(h), 3'(v), hs_act, vs_act, bl, ls, fs};
  endfunction

  // Advance reference for one edge.
  task automatic model_edge(input logic en);
    e_ls = 1'b0;
    e_fs = 1'b0;
    if (en) begin
      if (e_h == 15) begin
        e_h  = 0;
        e_ls = 1'b1;
        if (e_v == 7) begin
          e_v  = 0;
          e_fs = 1'b1;
        end else begin
          e_v = e_v + 1;
        end
      end else begin
        e_h = e_h + 1;
      end
    end
  endtask

  // Edge then sample 1 ns later; inputs are changed at that point too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    pix_en = 1'b0;
    step();
    step();
    e_h = 0; e_v = 0; e_ls = 1'b0; e_fs = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [27:0] exp;
    do_reset();
    // (0,0), syncs idle (1 for active-low, 0 for active-high), blank 0.
    exp = {4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
           4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs_vec() !== exp) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs_vec(), exp);
    end
  endtask

  task automatic test_free_run();
    int last_fs;
    int nfs;
    logic [27:0] exp;
    rst     = 1'b0;
    pix_en  = 1'b1;
    last_fs = 0;
    nfs     = 0;
    for (int cyc = 1; cyc <= 2 * 128 + 20; cyc++) begin
      step();
      model_edge(1'b1);
      exp = exp_vec(e_h, e_v, e_ls, e_fs, 1'b0);
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL free_run cyc %0d: got %h expected %h", cyc, obs_vec(), exp);
      end
      if (frame_start === 1'b1) begin
        nfs++;
        checks++;
        if (cyc - last_fs != 128) begin
          errors++;
          $display("FAIL frame_period: got %0d expected 128", cyc - last_fs);
        end
        last_fs = cyc;
      end
    end
    checks++;
    if (nfs != 2) begin
      errors++;
      $display("FAIL frame_count: got %0d expected 2", nfs);
    end
  endtask

  task automatic test_enable_gaps();
    int last_fs;
    int nfs;
    logic [27:0] exp;
    do_reset();
    rst     = 1'b0;
    last_fs = -1;
    nfs     = 0;
    for (int i = 0; i < 3 * 128 * 2 + 30; i++) begin
      pix_en = (i % 3 == 0);
      step();
      model_edge(pix_en);
      exp = exp_vec(e_h, e_v, e_ls, e_fs, 1'b0);
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL enable_gaps i %0d: got %h expected %h", i, obs_vec(), exp);
      end
      if (frame_start === 1'b1) begin
        nfs++;
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != 384) begin
            errors++;
            $display("FAIL gated_frame_period: got %0d expected 384", i - last_fs);
          end
        end
        last_fs = i;
      end
    end
    checks++;
    if (nfs != 2) begin
      errors++;
      $display("FAIL gated_frame_count: got %0d expected 2", nfs);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [27:0] exp;
    do_reset();
    rst    = 1'b0;
    pix_en = 1'b1;
    for (int i = 0; i < 37; i++) begin
      step();
      model_edge(1'b1);
    end
    checks++;
    if (hcount !== 4'd5 || vcount !== 3'd2) begin
      errors++;
      $display("FAIL reach_5_2: got (%0d,%0d) expected (5,2)", hcount, vcount);
    end
    rst = 1'b1;
    step();
    exp = exp_vec(0, 0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== exp) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", obs_vec(), exp);
    end
    // Release: first enabled edge moves to (1,0) with no pulses.
    rst = 1'b0;
    e_h = 0; e_v = 0;
    step();
    model_edge(1'b1);
    exp = exp_vec(e_h, e_v, e_ls, e_fs, 1'b0);
    checks++;
    if (obs_vec() !== exp) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs_vec(), exp);
    end
  endtask

  task automatic test_hold_on_disable();
    logic [27:0] snap;
    // Currently at (1,0); run to hcount 11 (in hsync) then stall.
    pix_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      model_edge(1'b1);
    end
    pix_en = 1'b0;
    snap = exp_vec(11, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_vec() !== snap) begin
        errors++;
        $display("FAIL hold i %0d: got %h expected %h", i, obs_vec(), snap);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    e_h = 0; e_v = 0; e_ls = 1'b0; e_fs = 1'b0;
    test_reset();
    test_free_run();
    test_enable_gaps();
    test_reset_mid_frame();
    test_hold_on_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
